// File: rtl/iop_ingress_packer_pkg.sv
// rtl/iop_ingress_packer_pkg.sv - shared lane geometry and helpers for the ingress packer
//   IOP_LANES : beats per packed IOP word
//   LANE_W    : width of the assembly lane index
//   FRM_CNT_W : width of the completed-frame counter
package iop_ingress_packer_pkg;

  localparam int IOP_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int FRM_CNT_W = 16;

  typedef logic [LANE_W-1:0]    lane_t;
  typedef logic [IOP_LANES-1:0] keep_t;

  // Lanes 0..lane inclusive are valid when a word closes at 'lane'.
  function automatic keep_t keep_for_lane(input lane_t lane);
    keep_t k;
    for (int i = 0; i < IOP_LANES; i++) begin
      k[i] = (LANE_W'(i) <= lane);
    end
    return k;
  endfunction

endpackage

// File: rtl/iop_pk_outreg.sv
// rtl/iop_pk_outreg.sv - packed-word output register with load/hold/clear handshake
//   clk, rstn            : clock, synchronous active-low reset
//   load                 : capture load_tdata/load_tkeep/load_tlast this cycle
//   load_tdata/tkeep/tlast : word being produced by the assembler
//   pk_tready            : downstream accepts the held word
//   pk_tvalid/tdata/tkeep/tlast : registered output word
module iop_pk_outreg
  import iop_ingress_packer_pkg::*;
#(
  parameter int pIOPS_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic [pIOPS_WIDTH-1:0] load_tdata,
  input  logic [IOP_LANES-1:0]   load_tkeep,
  input  logic                   load_tlast,
  input  logic                   pk_tready,
  output logic                   pk_tvalid,
  output logic [pIOPS_WIDTH-1:0] pk_tdata,
  output logic [IOP_LANES-1:0]   pk_tkeep,
  output logic                   pk_tlast
);

  // The upstream only asserts load when the slot is empty or draining this
  // cycle, so a load always wins and gives back-to-back words without a bubble.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pk_tvalid <= 1'b0;
      pk_tdata  <= '0;
      pk_tkeep  <= '0;
      pk_tlast  <= 1'b0;
    end else if (load) begin
      pk_tvalid <= 1'b1;
      pk_tdata  <= load_tdata;
      pk_tkeep  <= load_tkeep;
      pk_tlast  <= load_tlast;
    end else if (pk_tready) begin
      pk_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/iop_ingress_packer.sv
// rtl/iop_ingress_packer.sv - packs up to four stream beats into one IOP word
//   clk, rstn     : clock, synchronous active-low reset
//   ss_t*         : input beat stream (tvalid/tdata/tlast in, tready out)
//   pk_t*         : packed word stream (tvalid/tdata/tkeep/tlast out, tready in)
//   frm_cnt       : number of frames whose closing word was accepted downstream
//   INGRESS_ZPAD_EN : when defined, lanes outside pk_tkeep are driven to zero
module iop_ingress_packer
  import iop_ingress_packer_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pIOPS_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   pk_tvalid,
  output logic [pIOPS_WIDTH-1:0] pk_tdata,
  output logic [IOP_LANES-1:0]   pk_tkeep,
  output logic                   pk_tlast,
  input  logic                   pk_tready,
  output logic [FRM_CNT_W-1:0]   frm_cnt
);

  lane_t                                 lane_q;
  logic [IOP_LANES-1:0][pDATA_WIDTH-1:0] asm_q;
  logic [IOP_LANES-1:0][pDATA_WIDTH-1:0] asm_next;
  logic [pIOPS_WIDTH-1:0]                word;
  keep_t                                 keep;
  logic                                  accept;
  logic                                  complete;

  // Input is accepted whenever the output slot is free or frees this cycle.
  assign ss_tready = rstn & (~pk_tvalid | pk_tready);
  assign accept    = ss_tvalid & ss_tready;
  assign complete  = accept & ((lane_q == LANE_W'(IOP_LANES - 1)) | ss_tlast);
  assign keep      = keep_for_lane(lane_q);

  // The closing beat goes straight into the outgoing word rather than
  // waiting a cycle in the assembly register.
  always_comb begin
    asm_next         = asm_q;
    asm_next[lane_q] = ss_tdata;
  end

`ifdef INGRESS_ZPAD_EN
  always_comb begin
    word = '0;
    for (int i = 0; i < IOP_LANES; i++) begin
      word[i*pDATA_WIDTH +: pDATA_WIDTH] = keep[i] ? asm_next[i] : '0;
    end
  end
`else
  assign word = asm_next;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else if (accept) begin
      asm_q  <= asm_next;
      lane_q <= complete ? '0 : lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      frm_cnt <= '0;
    end else if (pk_tvalid && pk_tready && pk_tlast) begin
      frm_cnt <= frm_cnt + FRM_CNT_W'(1);
    end
  end

  iop_pk_outreg #(
    .pIOPS_WIDTH(pIOPS_WIDTH)
  ) u_outreg (
    .clk        (clk),
    .rstn       (rstn),
    .load       (complete),
    .load_tdata (word),
    .load_tkeep (keep),
    .load_tlast (ss_tlast),
    .pk_tready  (pk_tready),
    .pk_tvalid  (pk_tvalid),
    .pk_tdata   (pk_tdata),
    .pk_tkeep   (pk_tkeep),
    .pk_tlast   (pk_tlast)
  );

endmodule

// File: tb/tb_iop_ingress_packer.sv
// tb/tb_iop_ingress_packer.sv - self-checking bench for iop_ingress_packer
module tb_iop_ingress_packer;

  localparam int DW = 32;
  localparam int IW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tlast = 1'b0;
  logic          ss_tready;
  logic          pk_tvalid;
  logic [IW-1:0] pk_tdata;
  logic [3:0]    pk_tkeep;
  logic          pk_tlast;
  logic          pk_tready = 1'b0;
  logic [15:0]   frm_cnt;

  always #5 clk = ~clk;

  iop_ingress_packer #(.pDATA_WIDTH(DW), .pIOPS_WIDTH(IW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .pk_tvalid (pk_tvalid),
    .pk_tdata  (pk_tdata),
    .pk_tkeep  (pk_tkeep),
    .pk_tlast  (pk_tlast),
    .pk_tready (pk_tready),
    .frm_cnt   (frm_cnt)
  );

  typedef struct {
    logic [IW-1:0] data;
    logic [3:0]    keep;
    logic          last;
  } word_t;

  typedef struct {
    int          nbeats;
    logic [31:0] first;
    int          exp_words;
    logic [3:0]  exp_keep;
  } vec_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    words_seen = 0;
  int    exp_frames = 0;
  logic [3:0] last_keep_seen = '0;
  logic       last_last_seen = 1'b0;
  logic       rand_rdy = 1'b0;
  logic       rdy_force = 1'b1;

  always @(posedge clk) begin
    #1;
    pk_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] lane_mask(input logic [3:0] keep);
    logic [IW-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef INGRESS_ZPAD_EN
      m[i*DW +: DW] = '1;
`else
      if (keep[i]) m[i*DW +: DW] = '1;
`endif
    end
    return m;
  endfunction

  // Monitor: every handshake pops the model's next word; ready rule checked each cycle.
  always @(negedge clk) begin
    word_t         e;
    logic [IW-1:0] m;
    check("ss_tready_rule", ss_tready, rstn && (!pk_tvalid || pk_tready));
    if (rstn && pk_tvalid && pk_tready) begin
      words_seen++;
      last_keep_seen = pk_tkeep;
      last_last_seen = pk_tlast;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h keep %0h last %0b with nothing expected",
                 pk_tdata, pk_tkeep, pk_tlast);
      end else begin
        e = exp_q.pop_front();
        m = lane_mask(e.keep);
        check("word", {pk_tdata & m, pk_tkeep, pk_tlast}, {e.data & m, e.keep, e.last});
      end
    end
  end

  // Reference model: a frame of n beats becomes ceil(n/4) words, lanes filled in order.
  task automatic push_frame(input logic [DW-1:0] beats[$]);
    int n;
    n = beats.size();
    for (int i = 0; i < n; i += 4) begin
      word_t w;
      int    k;
      k = (n - i < 4) ? n - i : 4;
      w.data = '0;
      for (int j = 0; j < k; j++) w.data[j*DW +: DW] = beats[i+j];
      w.keep = 4'((1 << k) - 1);
      w.last = (i + 4 >= n);
      exp_q.push_back(w);
    end
    exp_frames++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = l;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = ss_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got no ss_tready in %0d cycles expected acceptance", n);
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] beats[$], input int maxgap);
    push_frame(beats);
    for (int i = 0; i < beats.size(); i++) begin
      send_beat(beats[i], i == beats.size() - 1, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pk_tvalid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || pk_tvalid) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t          tbl[7];
    logic [DW-1:0] b[$];
    logic [IW-1:0] held;
    int            base;
    int            n;

    tbl[0] = '{8,  32'h1,   2, 4'hF};
    tbl[1] = '{3,  32'hA,   1, 4'h7};
    tbl[2] = '{1,  32'h55,  1, 4'h1};
    tbl[3] = '{4,  32'h100, 1, 4'hF};
    tbl[4] = '{5,  32'h200, 2, 4'h1};
    tbl[5] = '{12, 32'h300, 3, 4'hF};
    tbl[6] = '{6,  32'h400, 2, 4'h3};

    // Reset state, ss_tready held low during reset even with pk_tready high.
    rstn = 1'b0;
    rdy_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pk_tvalid", pk_tvalid, 1'b0);
    check("rst_pk_tdata", pk_tdata, '0);
    check("rst_pk_tkeep", pk_tkeep, 4'h0);
    check("rst_pk_tlast", pk_tlast, 1'b0);
    check("rst_frm_cnt", frm_cnt, 16'h0);
    check("rst_ss_tready", ss_tready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Table-driven frames with pk_tready held high.
    for (int v = 0; v < 7; v++) begin
      b.delete();
      for (int i = 0; i < tbl[v].nbeats; i++) b.push_back(tbl[v].first + 32'(i));
      base = words_seen;
      send_frame(b, 0);
      drain();
      check($sformatf("vec%0d_words", v), words_seen - base, tbl[v].exp_words);
      check($sformatf("vec%0d_keep", v), last_keep_seen, tbl[v].exp_keep);
      check($sformatf("vec%0d_last", v), last_last_seen, 1'b1);
    end
    check("table_frm_cnt", frm_cnt, 16'(exp_frames));

    // Downstream stall after the first word: input blocked, output held.
    rdy_force = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(32'h21 + 32'(i));
    fork
      send_frame(b, 0);
      begin
        n = 0;
        @(negedge clk);
        while (!pk_tvalid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_word_seen", pk_tvalid, 1'b1);
        held = pk_tdata;
        for (int i = 0; i < 5; i++) begin
          check("stall_ss_tready", ss_tready, 1'b0);
          check("stall_hold", pk_tdata, held);
          @(negedge clk);
        end
        rdy_force = 1'b1;
      end
    join
    drain();
    check("stall_frm_cnt", frm_cnt, 16'(exp_frames));

    // Reset mid-frame discards the partial assembly.
    send_beat(32'h31, 1'b0, 0);
    send_beat(32'h32, 1'b0, 0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    @(negedge clk);
    check("midrst_pk_tvalid", pk_tvalid, 1'b0);
    check("midrst_frm_cnt", frm_cnt, 16'h0);
    @(posedge clk);
    #1;
    b.delete();
    for (int i = 0; i < 4; i++) b.push_back(32'h11 + 32'(i));
    base = words_seen;
    send_frame(b, 0);
    drain();
    check("midrst_words", words_seen - base, 1);
    check("midrst_keep", last_keep_seen, 4'hF);
    check("midrst_frm_cnt_after", frm_cnt, 16'h1);

    // Randomized frames with random gaps and random downstream backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      b.delete();
      n = $urandom_range(1, 13);
      for (int i = 0; i < n; i++) b.push_back($urandom);
      send_frame(b, 2);
    end
    drain();
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    check("rand_frm_cnt", frm_cnt, 16'(exp_frames));

    // frm_cnt wrap: 65535 single-beat frames, then one more.
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    for (int i = 0; i < 65535; i++) begin
      b.delete();
      b.push_back(DW'(i));
      send_frame(b, 0);
    end
    drain();
    check("wrap_pre", frm_cnt, 16'hFFFF);
    b.delete();
    b.push_back(32'hCAFE);
    send_frame(b, 0);
    drain();
    check("wrap_post", frm_cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
